// File: rtl/serial_mag_compare.sv
// Sequential W-bit magnitude comparator: streams operand bit pairs MSB first to an
// external 1-bit K/L comparator stage and stops at the first differing bit.
module serial_mag_compare #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_word,
  input  logic [W-1:0] b_word,
  output logic         bit_a,
  output logic         bit_b,
  input  logic         cmp_k,
  input  logic         cmp_l,
  output logic         busy,
  output logic         done,
  output logic         a_gt_b,
  output logic         a_lt_b,
  output logic         a_eq_b,
  output logic         err
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shA_q, shA_d;
  logic [W-1:0]  shB_q, shB_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          gt_q, gt_d;
  logic          lt_q, lt_d;
  logic          eq_q, eq_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shA_q   <= '0;
      shB_q   <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shA_q   <= shA_d;
      shB_q   <= shB_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      err_q   <= err_d;
    end
  end

  // Shift registers are cleared on leaving SCAN so bit_a/bit_b idle at 0.
  always_comb begin
    state_d = state_q;
    shA_d   = shA_q;
    shB_d   = shB_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shA_d   = a_word;
          shB_d   = b_word;
          idx_d   = IW'(W - 1);
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          err_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        case ({cmp_k, cmp_l})
          2'b11: begin
            if (idx_q == '0) begin
              eq_d    = 1'b1;
              shA_d   = '0;
              shB_d   = '0;
              state_d = DONE;
            end else begin
              shA_d = shA_q << 1;
              shB_d = shB_q << 1;
              idx_d = idx_q - 1'b1;
            end
          end
          2'b10: begin
            lt_d    = 1'b1;
            shA_d   = '0;
            shB_d   = '0;
            state_d = DONE;
          end
          2'b01: begin
            gt_d    = 1'b1;
            shA_d   = '0;
            shB_d   = '0;
            state_d = DONE;
          end
          default: begin
            err_d   = 1'b1;
            shA_d   = '0;
            shB_d   = '0;
            state_d = DONE;
          end
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bit_a  = shA_q[W-1];
  assign bit_b  = shB_q[W-1];
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;
  assign a_eq_b = eq_q;
  assign err    = err_q;

endmodule
